seven_seg_scan_mux: RTL

Time-multiplexed driver for an N-digit common-anode seven-segment display. It is the parametrised successor to the dual-digit driver. The block owns its own refresh counter instead of using an external divided clock. It adds three behaviours: per-digit blanking, a dead-time between digits to suppress ghosting, and a 16-level brightness duty. Hex values are latched once per frame so a display never shows a torn frame. It sits between the top-level switch/data logic and the display pins.

---
 rtl/seven_seg_scan_mux.sv | 120 ++++++++++++
 1 files changed

// File: rtl/seven_seg_scan_mux.sv
// Time-multiplexed driver for an N-digit common-anode seven-segment display with
// per-frame shadow latching, per-slot dead time, 16-level brightness and per-digit blanking.
module seven_seg_scan_mux #(
    parameter int NUM_DIGITS   = 2,
    parameter int DWELL_CYCLES = 24000,
    parameter int DEAD_CYCLES  = 8,
    localparam int IDX_W       = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4*NUM_DIGITS-1:0] digits,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   digit_en,
    output logic [6:0]              sevenseg,
    output logic [IDX_W-1:0]        digit_idx,
    output logic                    frame_start
);

    localparam int          CNT_W  = $clog2(DWELL_CYCLES);
    localparam int unsigned SPAN   = DWELL_CYCLES - DEAD_CYCLES;
    localparam int unsigned DEAD_U = DEAD_CYCLES;

    logic [CNT_W-1:0]        cnt;
    logic [IDX_W-1:0]        idx;
    logic [4*NUM_DIGITS-1:0] digit_sh;
    logic [NUM_DIGITS-1:0]   blank_sh;
    logic [3:0]              bright_sh;

    logic                    cnt_last;
    logic                    idx_last;
    logic                    capture;
    logic [31:0]             on_len;
    logic [31:0]             cnt_w;
    logic [3:0]              sel_digit;
    logic                    sel_blank;
    logic                    lit;
    logic [NUM_DIGITS-1:0]   en_next;

    function automatic logic [6:0] decode(input logic [3:0] hex);
        logic [6:0] seg;
        case (hex)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0011000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return seg;
    endfunction

    assign cnt_last = (cnt == CNT_W'(DWELL_CYCLES - 1));
    assign idx_last = (idx == IDX_W'(NUM_DIGITS - 1));
    assign capture  = (cnt == '0) && (idx == '0);
    assign cnt_w    = 32'(cnt);

    // Product is formed at 32 bits before the shift so no duty step is lost.
    assign on_len = (SPAN * (32'(bright_sh) + 32'd1)) >> 4;

    always_comb begin
        sel_digit = '0;
        sel_blank = 1'b1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx == IDX_W'(k)) begin
                sel_digit = digit_sh[4*k +: 4];
                sel_blank = blank_sh[k];
            end
        end
    end

    assign lit = (cnt_w >= DEAD_U) && ((cnt_w - DEAD_U) < on_len) && !sel_blank;

    always_comb begin
        en_next = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            en_next[k] = !(lit && (idx == IDX_W'(k)));
        end
    end

    // Reset blanks the pins immediately and parks the shadow in the all-blank state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt         <= '0;
            idx         <= '0;
            digit_sh    <= '0;
            blank_sh    <= '1;
            bright_sh   <= '0;
            digit_en    <= '1;
            sevenseg    <= 7'h7F;
            digit_idx   <= '0;
            frame_start <= 1'b0;
        end else begin
            cnt <= cnt_last ? '0 : cnt + CNT_W'(1);
            if (cnt_last) begin
                idx <= idx_last ? '0 : idx + IDX_W'(1);
            end
            if (capture) begin
                digit_sh  <= digits;
                blank_sh  <= blank;
                bright_sh <= brightness;
            end
            digit_en    <= en_next;
            sevenseg    <= lit ? decode(sel_digit) : 7'h7F;
            digit_idx   <= idx;
            frame_start <= capture;
        end
    end

endmodule
